// File: rtl/hpi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : hpi_responder
// Description : Host-port-interface responder. An asynchronous-style host bus
//               (cs_n / r_n / w_n strobes) is sampled on Clk and decoded into
//               four registers: DATA (window onto internal word memory),
//               MAILBOX (host<->device mailboxes), ADDRESS (byte address
//               pointer) and STATUS.
// Revision    : 1.0 - initial release
//
// Parameters
//   MEM_AW          word-address width; memory holds 2^MEM_AW 16-bit words
//
// Ports
//   Clk             single clock, all inputs synchronous to it
//   Reset           synchronous, active-high reset
//   hpi_address     register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
//   hpi_cs_n        chip select, active-low
//   hpi_r_n         read strobe, active-low
//   hpi_w_n         write strobe, active-low
//   hpi_data_in     host write data
//   hpi_data_out    read data, valid one cycle after read start, held
//   hpi_int         high while the device-to-host mailbox is full
//   lcl_mbx_wr      pulse: local side loads device-to-host mailbox
//   lcl_mbx_wdata   device-to-host mailbox data
//   lcl_mbx_ack     pulse: local side consumes host-to-device mailbox
//   host_mbx_valid  host-to-device mailbox full
//   host_mbx_data   host-to-device mailbox contents
//
// Configuration
//   HPI_AUTOINC_EN  when defined, every DATA read/write start advances the
//                   byte address by 2 after the access
// ============================================================================
module hpi_responder #(
    parameter int MEM_AW = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  hpi_address,
    input  logic        hpi_cs_n,
    input  logic        hpi_r_n,
    input  logic        hpi_w_n,
    input  logic [15:0] hpi_data_in,
    output logic [15:0] hpi_data_out,
    output logic        hpi_int,
    input  logic        lcl_mbx_wr,
    input  logic [15:0] lcl_mbx_wdata,
    input  logic        lcl_mbx_ack,
    output logic        host_mbx_valid,
    output logic [15:0] host_mbx_data
);

    localparam int         c_MEM_WORDS  = 1 << MEM_AW;
    localparam logic [1:0] c_SEL_DATA   = 2'd0;
    localparam logic [1:0] c_SEL_MBX    = 2'd1;
    localparam logic [1:0] c_SEL_ADDR   = 2'd2;
    localparam logic [1:0] c_SEL_STATUS = 2'd3;

`ifdef HPI_AUTOINC_EN
    localparam bit c_AUTOINC = 1'b1;
`else
    localparam bit c_AUTOINC = 1'b0;
`endif

    // Sampled strobes. Deliberately not reset: the edge detector below is
    // what suppresses a strobe held across reset.
    logic r_cs_n;
    logic r_r_n;
    logic r_w_n;

    logic        r_active_d;
    logic [15:0] r_addr;
    logic [15:0] r_data_out;
    logic [15:0] r_host_mbx_data;
    logic        r_host_mbx_valid;
    logic [15:0] r_dev_mbx;
    logic        r_dev_full;
    logic        r_proto_err;
    logic        r_overrun;

    logic [15:0] r_mem [0:c_MEM_WORDS-1];

    logic              w_active;
    logic              w_both;
    logic              w_start;
    logic              w_wr_start;
    logic              w_rd_start;
    logic [MEM_AW-1:0] w_mem_idx;
    logic [15:0]       w_mem_rdata;
    logic [15:0]       w_status;

    always_ff @(posedge Clk) begin
        r_cs_n <= hpi_cs_n;
        r_r_n  <= hpi_r_n;
        r_w_n  <= hpi_w_n;
    end

    // An access starts on the first sampled cycle with chip select and any
    // strobe low. Both strobes low is a protocol error and has no effect.
    assign w_active   = !r_cs_n && (!r_r_n || !r_w_n);
    assign w_both     = !r_cs_n && !r_r_n && !r_w_n;
    assign w_start    = w_active && !r_active_d;
    assign w_wr_start = w_start && !w_both && !r_w_n;
    assign w_rd_start = w_start && !w_both && !r_r_n;

    // Byte address: bit 0 ignored, upper bits alias onto the memory size.
    assign w_mem_idx   = r_addr[MEM_AW:1];
    assign w_mem_rdata = r_mem[w_mem_idx];
    assign w_status    = {12'b0, r_overrun, r_proto_err, r_dev_full, r_host_mbx_valid};

    // Memory contents survive reset; only a write start outside reset lands.
    always_ff @(posedge Clk) begin
        if (!Reset && w_wr_start && (hpi_address == c_SEL_DATA)) begin
            r_mem[w_mem_idx] <= hpi_data_in;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            // Treat the bus as already mid-access so a strobe still low after
            // reset release must rise and fall again before it counts.
            r_active_d       <= 1'b1;
            r_addr           <= 16'h0000;
            r_data_out       <= 16'h0000;
            r_host_mbx_data  <= 16'h0000;
            r_host_mbx_valid <= 1'b0;
            r_dev_mbx        <= 16'h0000;
            r_dev_full       <= 1'b0;
            r_proto_err      <= 1'b0;
            r_overrun        <= 1'b0;
        end else begin
            r_active_d <= w_active;

            if (w_both) begin
                r_proto_err <= 1'b1;
            end

            if (w_wr_start) begin
                case (hpi_address)
                    c_SEL_DATA: begin
                        if (c_AUTOINC) begin
                            r_addr <= r_addr + 16'd2;
                        end
                    end
                    c_SEL_MBX: begin
                        r_host_mbx_data <= hpi_data_in;
                        // An ack in the same cycle frees the slot first.
                        if (r_host_mbx_valid && !lcl_mbx_ack) begin
                            r_overrun <= 1'b1;
                        end
                    end
                    c_SEL_ADDR: begin
                        r_addr <= hpi_data_in;
                    end
                    c_SEL_STATUS: begin
                        if (hpi_data_in[2]) begin
                            r_proto_err <= 1'b0;
                        end
                        if (hpi_data_in[3]) begin
                            r_overrun <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            if (w_rd_start) begin
                case (hpi_address)
                    c_SEL_DATA: begin
                        r_data_out <= w_mem_rdata;
                        if (c_AUTOINC) begin
                            r_addr <= r_addr + 16'd2;
                        end
                    end
                    c_SEL_MBX:    r_data_out <= r_dev_mbx;
                    c_SEL_ADDR:   r_data_out <= r_addr;
                    c_SEL_STATUS: r_data_out <= w_status;
                    default:      r_data_out <= r_data_out;
                endcase
            end

            // Host write wins over a simultaneous local ack.
            if (w_wr_start && (hpi_address == c_SEL_MBX)) begin
                r_host_mbx_valid <= 1'b1;
            end else if (lcl_mbx_ack) begin
                r_host_mbx_valid <= 1'b0;
            end

            // A local load wins over a simultaneous host read; the read
            // above still returns the previous contents.
            if (lcl_mbx_wr) begin
                r_dev_mbx  <= lcl_mbx_wdata;
                r_dev_full <= 1'b1;
            end else if (w_rd_start && (hpi_address == c_SEL_MBX)) begin
                r_dev_full <= 1'b0;
            end
        end
    end

    assign hpi_data_out   = r_data_out;
    assign hpi_int        = r_dev_full;
    assign host_mbx_valid = r_host_mbx_valid;
    assign host_mbx_data  = r_host_mbx_data;

endmodule
`default_nettype wire

// File: tb/tb_hpi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_hpi_responder
// Description : Self-checking bench for hpi_responder. A transaction-level
//               model of the register file and mailboxes is advanced at the
//               clock edge where each access takes effect; a compare process
//               checks all outputs against it every cycle. Directed scenarios
//               carry literal expectations, then randomized traffic follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hpi_responder;

    localparam int MEM_AW    = 8;
    localparam int MEM_WORDS = 1 << MEM_AW;
`ifdef HPI_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam int K_NONE  = 0;
    localparam int K_WRITE = 1;
    localparam int K_READ  = 2;
    localparam int K_PROTO = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  hpi_address = 2'd0;
    logic        hpi_cs_n = 1'b1;
    logic        hpi_r_n = 1'b1;
    logic        hpi_w_n = 1'b1;
    logic [15:0] hpi_data_in = 16'h0000;
    logic [15:0] hpi_data_out;
    logic        hpi_int;
    logic        lcl_mbx_wr = 1'b0;
    logic [15:0] lcl_mbx_wdata = 16'h0000;
    logic        lcl_mbx_ack = 1'b0;
    logic        host_mbx_valid;
    logic [15:0] host_mbx_data;

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state
    logic [15:0] m_mem [MEM_WORDS];
    logic [15:0] m_out, m_addr, m_hdata, m_dmbx;
    bit          m_hvalid, m_dfull, m_proto, m_ovr;

    always #5 clk = ~clk;

    hpi_responder #(.MEM_AW(MEM_AW)) dut (
        .Clk            (clk),
        .Reset          (rst),
        .hpi_address    (hpi_address),
        .hpi_cs_n       (hpi_cs_n),
        .hpi_r_n        (hpi_r_n),
        .hpi_w_n        (hpi_w_n),
        .hpi_data_in    (hpi_data_in),
        .hpi_data_out   (hpi_data_out),
        .hpi_int        (hpi_int),
        .lcl_mbx_wr     (lcl_mbx_wr),
        .lcl_mbx_wdata  (lcl_mbx_wdata),
        .lcl_mbx_ack    (lcl_mbx_ack),
        .host_mbx_valid (host_mbx_valid),
        .host_mbx_data  (host_mbx_data)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int word_of(input logic [15:0] byte_addr);
        return (int'(byte_addr) / 2) % MEM_WORDS;
    endfunction

    task automatic model_reset();
        m_out = 16'h0; m_addr = 16'h0; m_hdata = 16'h0; m_dmbx = 16'h0;
        m_hvalid = 0; m_dfull = 0; m_proto = 0; m_ovr = 0;
    endtask

    // Effect of one clock edge: an optional host access plus local pulses.
    task automatic model_apply(input int kind, input logic [1:0] a, input logic [15:0] d,
                               input bit lw, input logic [15:0] lwd, input bit lack);
        bit host_mbx_wr = (kind == K_WRITE) && (a == 2'd1);
        bit dev_rd      = (kind == K_READ)  && (a == 2'd1);
        if (kind == K_WRITE) begin
            case (a)
                2'd0: begin
                    m_mem[word_of(m_addr)] = d;
                    if (AUTOINC) m_addr = m_addr + 16'd2;
                end
                2'd1: begin
                    if (m_hvalid && !lack) m_ovr = 1;
                    m_hdata = d;
                end
                2'd2: m_addr = d;
                default: begin
                    if (d[2]) m_proto = 0;
                    if (d[3]) m_ovr = 0;
                end
            endcase
        end else if (kind == K_READ) begin
            case (a)
                2'd0: begin
                    m_out = m_mem[word_of(m_addr)];
                    if (AUTOINC) m_addr = m_addr + 16'd2;
                end
                2'd1: m_out = m_dmbx;
                2'd2: m_out = m_addr;
                default: m_out = (m_ovr ? 16'd8 : 16'd0) + (m_proto ? 16'd4 : 16'd0)
                               + (m_dfull ? 16'd2 : 16'd0) + (m_hvalid ? 16'd1 : 16'd0);
            endcase
        end else if (kind == K_PROTO) begin
            m_proto = 1;
        end
        if (host_mbx_wr)  m_hvalid = 1;
        else if (lack)    m_hvalid = 0;
        if (lw) begin
            m_dmbx  = lwd;
            m_dfull = 1;
        end else if (dev_rd) begin
            m_dfull = 0;
        end
    endtask

    // Every cycle: outputs must equal the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("data_out", hpi_data_out, m_out);
            check("hpi_int", {15'b0, hpi_int}, {15'b0, m_dfull});
            check("host_valid", {15'b0, host_mbx_valid}, {15'b0, m_hvalid});
            check("host_data", host_mbx_data, m_hdata);
        end
    end

    // Strobe low for 'hold' cycles; local pulses land on the effect edge.
    task automatic host_access(input int kind, input logic [1:0] a, input logic [15:0] d,
                               input int hold, input bit lw, input logic [15:0] lwd,
                               input bit lack);
        @(posedge clk); #1;
        hpi_address = a;
        hpi_data_in = d;
        hpi_cs_n    = 1'b0;
        hpi_r_n     = !(kind == K_READ  || kind == K_PROTO);
        hpi_w_n     = !(kind == K_WRITE || kind == K_PROTO);
        @(posedge clk); #1;
        if (lw) begin lcl_mbx_wr = 1'b1; lcl_mbx_wdata = lwd; end
        if (lack) lcl_mbx_ack = 1'b1;
        @(posedge clk);
        model_apply(kind, a, d, lw, lwd, lack);
        #1;
        lcl_mbx_wr  = 1'b0;
        lcl_mbx_ack = 1'b0;
        if (hold > 1) begin
            repeat (hold - 1) @(posedge clk);
            #1;
        end
        hpi_cs_n = 1'b1;
        hpi_r_n  = 1'b1;
        hpi_w_n  = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        host_access(K_WRITE, a, d, 1, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic rd(input logic [1:0] a);
        host_access(K_READ, a, 16'h0, 1, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic lcl_pulse(input bit lw, input logic [15:0] lwd, input bit lack);
        @(posedge clk); #1;
        if (lw) begin lcl_mbx_wr = 1'b1; lcl_mbx_wdata = lwd; end
        if (lack) lcl_mbx_ack = 1'b1;
        @(posedge clk);
        model_apply(K_NONE, 2'd0, 16'h0, lw, lwd, lack);
        #1;
        lcl_mbx_wr  = 1'b0;
        lcl_mbx_ack = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk);
            model_reset();
        end
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        do_reset(3);
        chk_en = 1'b1;
        check("rst_data_out", hpi_data_out, 16'h0000);
        check("rst_int", {15'b0, hpi_int}, 16'h0000);
        check("rst_valid", {15'b0, host_mbx_valid}, 16'h0000);
        rd(2'd3);
        check("rst_status", hpi_data_out, 16'h0000);

        // Data window and address pointer
        wr(2'd2, 16'h0010);
        wr(2'd0, 16'hBEEF);
        wr(2'd0, 16'hCAFE);
        wr(2'd2, 16'h0010);
        rd(2'd0);
        check("data_rd0", hpi_data_out, AUTOINC ? 16'hBEEF : 16'hCAFE);
        rd(2'd0);
        check("data_rd1", hpi_data_out, 16'hCAFE);
        rd(2'd2);
        check("addr_after", hpi_data_out, AUTOINC ? 16'h0014 : 16'h0010);

        // Aliasing and ignored bit 0: 0x0211 maps onto the same word as 0x0010
        wr(2'd2, 16'h0211);
        wr(2'd0, 16'h4242);
        wr(2'd2, 16'h0010);
        rd(2'd0);
        check("alias_rd", hpi_data_out, 16'h4242);

        // Host-to-device mailbox with overrun
        wr(2'd1, 16'h1234);
        check("hmbx_valid", {15'b0, host_mbx_valid}, 16'h0001);
        check("hmbx_data", host_mbx_data, 16'h1234);
        wr(2'd1, 16'h5678);
        rd(2'd3);
        check("status_ovr", hpi_data_out, 16'h0009);
        lcl_pulse(1'b0, 16'h0, 1'b1);
        check("hmbx_acked", {15'b0, host_mbx_valid}, 16'h0000);
        wr(2'd3, 16'h0008);
        rd(2'd3);
        check("status_clr_ovr", hpi_data_out, 16'h0000);

        // Write together with ack on a full mailbox: no overrun
        wr(2'd1, 16'hAAAA);
        host_access(K_WRITE, 2'd1, 16'hBBBB, 1, 1'b0, 16'h0, 1'b1);
        check("wr_ack_data", host_mbx_data, 16'hBBBB);
        rd(2'd3);
        check("wr_ack_status", hpi_data_out, 16'h0001);
        lcl_pulse(1'b0, 16'h0, 1'b1);

        // Device-to-host mailbox and interrupt
        lcl_pulse(1'b1, 16'hA5A5, 1'b0);
        check("int_set", {15'b0, hpi_int}, 16'h0001);
        rd(2'd1);
        check("dmbx_rd", hpi_data_out, 16'hA5A5);
        check("int_clr", {15'b0, hpi_int}, 16'h0000);
        lcl_pulse(1'b1, 16'h1111, 1'b0);
        host_access(K_READ, 2'd1, 16'h0, 1, 1'b1, 16'h2222, 1'b0);
        check("dmbx_old", hpi_data_out, 16'h1111);
        check("dmbx_int_kept", {15'b0, hpi_int}, 16'h0001);
        rd(2'd1);
        check("dmbx_new", hpi_data_out, 16'h2222);

        // Protocol error
        wr(2'd2, 16'h0020);
        wr(2'd0, 16'h1357);
        wr(2'd2, 16'h0020);
        host_access(K_PROTO, 2'd0, 16'hFFFF, 2, 1'b0, 16'h0, 1'b0);
        rd(2'd3);
        check("proto_status", hpi_data_out, 16'h0004);
        rd(2'd2);
        check("proto_addr", hpi_data_out, 16'h0020);
        rd(2'd0);
        check("proto_mem", hpi_data_out, 16'h1357);
        wr(2'd3, 16'h0004);
        rd(2'd3);
        check("proto_clr", hpi_data_out, 16'h0000);

        // Long write strobe: exactly one write
        wr(2'd2, 16'h0042);
        wr(2'd0, 16'h0101);
        wr(2'd2, 16'h0040);
        host_access(K_WRITE, 2'd0, 16'h7777, 20, 1'b0, 16'h0, 1'b0);
        rd(2'd2);
        check("long_addr", hpi_data_out, AUTOINC ? 16'h0042 : 16'h0040);
        wr(2'd2, 16'h0042);
        rd(2'd0);
        check("long_next", hpi_data_out, 16'h0101);
        wr(2'd2, 16'h0040);
        rd(2'd0);
        check("long_word", hpi_data_out, 16'h7777);

        // Reset in the middle of a held mailbox write
        lcl_pulse(1'b1, 16'h5A5A, 1'b0);
        @(posedge clk); #1;
        hpi_address = 2'd1; hpi_data_in = 16'h9999; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        model_apply(K_WRITE, 2'd1, 16'h9999, 1'b0, 16'h0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        check("mid_rst_out", hpi_data_out, 16'h0000);
        check("mid_rst_int", {15'b0, hpi_int}, 16'h0000);
        check("mid_rst_valid", {15'b0, host_mbx_valid}, 16'h0000);
        check("mid_rst_hdata", host_mbx_data, 16'h0000);
        repeat (6) @(posedge clk);
        #1;
        hpi_cs_n = 1'b1; hpi_w_n = 1'b1;
        check("held_no_access", {15'b0, host_mbx_valid}, 16'h0000);
        rd(2'd3);
        check("held_status", hpi_data_out, 16'h0000);

        // Fill memory so any random DATA read has a known value
        for (int i = 0; i < MEM_WORDS; i++) begin
            wr(2'd2, 16'(i * 2));
            wr(2'd0, 16'($urandom));
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int sel = int'($urandom_range(0, 99));
            bit lw = ($urandom_range(0, 5) == 0);
            bit la = ($urandom_range(0, 5) == 0);
            logic [15:0] lwd = 16'($urandom);
            if (sel < 70) begin
                int k = (sel < 32) ? K_WRITE : (sel < 64) ? K_READ : K_PROTO;
                host_access(k, 2'($urandom_range(0, 3)), 16'($urandom),
                            int'($urandom_range(1, 4)), lw, lwd, la);
            end else if (sel < 90) begin
                lcl_pulse(lw, lwd, la);
            end else begin
                repeat (int'($urandom_range(1, 3))) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire
